// File: rtl/alu_unit.sv
// 32-bit datapath ALU with registered result and zero flag (one-clock latency).
// The zero flag drives branch resolution: BEQ through SUB, BGTZ through its own compare op.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic [2:0]       ALUCtl,
    output logic [WIDTH-1:0] Res,
    output logic             ZF
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_NOP  = 3'b011,
        OP_BGTZ = 3'b100,
        OP_RSVD = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0] res_d, res_q;
    logic             zf_d, zf_q;
    logic             slt_bit, gtz_bit;

    // True signed compare so that INT_MIN < positive holds despite subtraction overflow.
    assign slt_bit = $signed(Op1) < $signed(Op2);
    assign gtz_bit = ~Op1[WIDTH-1] & (|Op1);

    always_comb begin
        res_d = '0;
        case (alu_op_e'(ALUCtl))
            OP_AND:  res_d = Op1 & Op2;
            OP_OR:   res_d = Op1 | Op2;
            OP_ADD:  res_d = Op1 + Op2;
            OP_SUB:  res_d = Op1 - Op2;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_BGTZ: res_d = {{(WIDTH-1){1'b0}}, gtz_bit};
            default: res_d = '0;
        endcase
        zf_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            zf_q  <= 1'b1;
        end else begin
            res_q <= res_d;
            zf_q  <= zf_d;
        end
    end

    assign Res = res_q;
    assign ZF  = zf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes expected {ZF,Res} per cycle,
// a monitor pops one entry after every rising edge and compares.
module tb_alu_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  Op1, Op2;
    logic [2:0]    ALUCtl;
    logic [W-1:0]  Res;
    logic          ZF;

    int total = 0;
    int bad   = 0;
    int idx   = 0;
    logic [W:0] exp_q[$];

    alu_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Op1    (Op1),
        .Op2    (Op2),
        .ALUCtl (ALUCtl),
        .Res    (Res),
        .ZF     (ZF)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on sign-extended 64-bit values.
    function automatic logic [W:0] model(input bit rst, input logic [2:0] c,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, full;
        logic [W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        if (!rst) begin
            case (c)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: begin full = longint'(a) + longint'(b); r = full[W-1:0]; end
                3'd6: begin full = longint'(a) - longint'(b); r = full[W-1:0]; end
                3'd7: r = (sa < sb) ? 1 : 0;
                3'd4: r = (sa > 0) ? 1 : 0;
                default: r = '0;
            endcase
        end
        return {(r == '0), r};
    endfunction

    task automatic step(input bit rst, input logic [2:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst_n  = ~rst;
        ALUCtl = c;
        Op1    = a;
        Op2    = b;
        exp_q.push_back(model(rst, c, a, b));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            total++;
            if ({ZF, Res} !== e) begin
                bad++;
                $display("FAIL op%0d: got Res=%h ZF=%b, expected Res=%h ZF=%b",
                         idx, Res, ZF, e[W-1:0], e[W]);
            end
            idx++;
        end
    end

    initial begin
        rst_n = 1'b0; ALUCtl = 3'd0; Op1 = '0; Op2 = '0;
        // reset with arbitrary inputs
        step(1, 3'd2, 32'h1234_5678, 32'h1111_1111);
        step(1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        // directed
        step(0, 3'd0, 32'hAAAA_AAAA, 32'hCCCC_CCCC);
        step(0, 3'd1, 32'h0F0F_0F0F, 32'h3333_3333);
        step(0, 3'd2, 32'd5, 32'd6);
        step(0, 3'd2, 32'hFFFF_FFFF, 32'd1);
        step(0, 3'd6, 32'd8, 32'd5);
        step(0, 3'd6, 32'd5, 32'd5);
        step(0, 3'd6, 32'd0, 32'd1);
        step(0, 3'd7, 32'd4, 32'd8);
        step(0, 3'd7, 32'd8, 32'd4);
        step(0, 3'd7, 32'hFFFF_FFFF, 32'd1);
        step(0, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF);
        step(0, 3'd7, 32'h7FFF_FFFF, 32'h8000_0000);
        step(0, 3'd4, 32'hFFFF_FFFF, 32'd7);
        step(0, 3'd4, 32'd10, 32'hFFFF_FFFF);
        step(0, 3'd4, 32'd0, 32'd3);
        step(0, 3'd4, 32'h8000_0000, 32'd1);
        step(0, 3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(0, 3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        // mid-stream reset right after an ADD, with ADD still on the inputs
        step(0, 3'd2, 32'd100, 32'd23);
        step(1, 3'd2, 32'd100, 32'd23);
        step(0, 3'd2, 32'd100, 32'd23);
        // back-to-back random ops, occasional reset, biased operands
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a, b;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h8000_0000;
                2: a = $urandom_range(0, 3);
                3: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            step(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), a, b);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name:
alu_unit

Overview:
- 32-bit integer ALU for the single-cycle/pipelined datapath; executes the operation selected by the 3-bit ALU control code from the ALU decoder.
- Two operands in; result and zero flag out.
- Outputs are registered: one-clock latency, synchronous active-low reset.
- The zero flag feeds branch resolution (BEQ via SUB, BGTZ via the dedicated compare op).

Parameters:
- WIDTH, 32: operand/result width in bits. All behaviour below is stated for 32; it generalises to any WIDTH ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- Op1  input  WIDTH  operand A (rs).
- Op2  input  WIDTH  operand B (rt or immediate).
- ALUCtl  input  3  operation select.
- Res  output  WIDTH  registered result.
- ZF  output  1  registered zero flag; ZF = 1 iff Res == 0.

Behaviour:
- Reset: at a rising clk with rst_n = 0, Res <= 0 and ZF <= 1. Reset overrides any operation in the same cycle, including mid-stream.
- Normal operation: each rising clk with rst_n = 1 computes a result from the current Op1, Op2 and ALUCtl, then registers it into Res.
- ZF is registered in the same edge as (computed result == 0). ZF and Res are always mutually consistent.
- Latency: exactly 1 clk from input to output. Inputs are sampled every cycle; there is no handshake or stall.
- Operation encoding (signed means two's complement):
  - 000 AND: Op1 & Op2, bitwise.
  - 001 OR: Op1 | Op2, bitwise.
  - 010 ADD: Op1 + Op2, modulo 2^WIDTH. Carry/overflow discarded, no flag.
  - 110 SUB: Op1 − Op2, modulo 2^WIDTH. Borrow discarded. Equal operands give 0 and ZF = 1 (BEQ support).
  - 111 SLT: 1 if signed(Op1) < signed(Op2), else 0, zero-extended to WIDTH. Must use a correct signed compare, not the sign bit of the subtraction: INT_MIN vs positive must give 1.
  - 100 BGTZ: 1 if signed(Op1) > 0, else 0, zero-extended. Op2 ignored. Op1 = 0 or negative gives 0 (ZF = 1); the branch is taken when ZF = 0.
  - 011 NOP: result 0, ZF = 1. Operands ignored.
  - 101 reserved: behaves exactly as NOP (result 0, ZF = 1).
- No X propagation from unused operands: Op2 is ignored for BGTZ/NOP/reserved.
- The result is a pure function of the sampled inputs. There is no internal state besides the output registers.

Test Plan:
- Reset: hold rst_n = 0 for 2 clks with arbitrary inputs -> Res = 0x00000000, ZF = 1. Assert rst_n = 0 mid-stream after an ADD -> the next edge gives Res = 0, ZF = 1.
- Logic ops:
  - AND, Op1 = 0xAAAAAAAA, Op2 = 0xCCCCCCCC -> Res = 0x88888888, ZF = 0, one clk later.
  - OR, Op1 = 0x0F0F0F0F, Op2 = 0x33333333 -> Res = 0x3F3F3F3F, ZF = 0.
- Arithmetic:
  - ADD 5 + 6 -> 0x0000000B, ZF = 0.
  - ADD 0xFFFFFFFF + 1 -> 0x00000000, ZF = 1 (wrap).
  - SUB 8 − 5 -> 3, ZF = 0.
  - SUB 5 − 5 -> 0, ZF = 1.
  - SUB 0 − 1 -> 0xFFFFFFFF.
- SLT:
  - 4 vs 8 -> 1.
  - 8 vs 4 -> 0 (ZF = 1).
  - 0xFFFFFFFF vs 1 -> 1.
  - 0x80000000 vs 0x7FFFFFFF -> 1.
  - 0x7FFFFFFF vs 0x80000000 -> 0.
- BGTZ:
  - Op1 = 0xFFFFFFFF -> Res = 0, ZF = 1.
  - Op1 = 10 -> Res = 1, ZF = 0.
  - Op1 = 0 -> Res = 0, ZF = 1.
  - Op1 = 0x80000000 -> 0.
- NOP/reserved and pipelining:
  - ALUCtl = 011 and 101 with Op1 = Op2 = 0xDEADBEEF -> Res = 0, ZF = 1.
  - Back-to-back ops changing every clk -> each result appears exactly one clk after its inputs, with no skipped or duplicated cycle.
